// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_univ
// Purpose  : WIDTH-bit universal register: hold, load, shift, rotate, ASR, clear.
//            Optional frame counter enabled by SHIFT_REG_UNIV_FRAME_EN.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_univ #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] Q,
    output logic             sout_msb,
    output logic             sout_lsb
`ifdef SHIFT_REG_UNIV_FRAME_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       frame_done
`endif
);

    localparam logic [2:0] c_MODE_HOLD  = 3'b000;
    localparam logic [2:0] c_MODE_LOAD  = 3'b001;
    localparam logic [2:0] c_MODE_SHL   = 3'b010;
    localparam logic [2:0] c_MODE_SHR   = 3'b011;
    localparam logic [2:0] c_MODE_ROL   = 3'b100;
    localparam logic [2:0] c_MODE_ROR   = 3'b101;
    localparam logic [2:0] c_MODE_ASR   = 3'b110;
    localparam logic [2:0] c_MODE_CLEAR = 3'b111;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

    always_comb begin
        w_q_next = r_q;
        case (mode)
            c_MODE_HOLD:  w_q_next = r_q;
            c_MODE_LOAD:  w_q_next = D;
            c_MODE_SHL:   w_q_next = {r_q[WIDTH-2:0], sin_l};
            c_MODE_SHR:   w_q_next = {sin_r, r_q[WIDTH-1:1]};
            c_MODE_ROL:   w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            c_MODE_ROR:   w_q_next = {r_q[0], r_q[WIDTH-1:1]};
            c_MODE_ASR:   w_q_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            c_MODE_CLEAR: w_q_next = RESET_VAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign Q        = r_q;
    assign sout_msb = r_q[WIDTH-1];
    assign sout_lsb = r_q[0];

`ifdef SHIFT_REG_UNIV_FRAME_EN
    localparam int             CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  c_CNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;
    logic          r_frame_done;
    logic          w_is_shift;

    // Codes SHL..ASR are contiguous; CLEAR is the only code above them.
    assign w_is_shift = (mode >= c_MODE_SHL) && (mode != c_MODE_CLEAR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (mode == c_MODE_LOAD || mode == c_MODE_CLEAR) begin
                r_cnt <= '0;
            end else if (w_is_shift) begin
                // Wrap at WIDTH so the counter never holds the value WIDTH.
                if (r_cnt == c_CNT_LAST) begin
                    r_cnt        <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign cnt        = r_cnt;
    assign frame_done = r_frame_done;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_univ.sv
`default_nettype none
// Self-checking bench for shift_reg_univ (WIDTH=8 and WIDTH=2 instances).
// Expected results are queued when stimulus is driven and popped after the edge.
module tb_shift_reg_univ;

    localparam logic [2:0] HOLD  = 3'b000;
    localparam logic [2:0] LOAD  = 3'b001;
    localparam logic [2:0] SHL   = 3'b010;
    localparam logic [2:0] SHR   = 3'b011;
    localparam logic [2:0] ROL   = 3'b100;
    localparam logic [2:0] ROR   = 3'b101;
    localparam logic [2:0] ASR   = 3'b110;
    localparam logic [2:0] CLEAR = 3'b111;

    typedef struct {
        logic [2:0] m;
        logic [7:0] d;
        logic       sl;
        logic       sr;
        logic       rn;
        logic [7:0] q;
        logic [3:0] cnt;
        logic       fd;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic [3:0] cnt;
        logic       fd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] mode = HOLD;
    logic [7:0] d8 = '0;
    logic       sin_l = 1'b0;
    logic       sin_r = 1'b0;
    logic [7:0] q8;
    logic       msb8, lsb8;

    logic       rst_n2 = 1'b0;
    logic [2:0] mode2 = HOLD;
    logic [1:0] d2 = '0;
    logic       sin_l2 = 1'b0;
    logic       sin_r2 = 1'b0;
    logic [1:0] q2;
    logic       msb2, lsb2;

`ifdef SHIFT_REG_UNIV_FRAME_EN
    logic [3:0] cnt8;
    logic       fd8;
    logic [1:0] cnt2;
    logic       fd2;
`endif

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .D(d8), .sin_l(sin_l), .sin_r(sin_r),
        .Q(q8), .sout_msb(msb8), .sout_lsb(lsb8)
`ifdef SHIFT_REG_UNIV_FRAME_EN
        , .cnt(cnt8), .frame_done(fd8)
`endif
    );

    shift_reg_univ #(.WIDTH(2), .RESET_VAL(2'b00)) dut2 (
        .clk(clk), .rst_n(rst_n2), .mode(mode2), .D(d2), .sin_l(sin_l2), .sin_r(sin_r2),
        .Q(q2), .sout_msb(msb2), .sout_lsb(lsb2)
`ifdef SHIFT_REG_UNIV_FRAME_EN
        , .cnt(cnt2), .frame_done(fd2)
`endif
    );

    // Drive one vector on the 8-bit DUT, queue its expectation, sample 1 time unit after the edge.
    task automatic step8(input vec_t v);
        @(negedge clk);
        mode = v.m; d8 = v.d; sin_l = v.sl; sin_r = v.sr; rst_n = v.rn;
        sb.push_back('{q: v.q, cnt: v.cnt, fd: v.fd});
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input vec_t v);
        @(negedge clk);
        mode2 = v.m; d2 = v.d[1:0]; sin_l2 = v.sl; sin_r2 = v.sr; rst_n2 = v.rn;
        sb.push_back('{q: v.q, cnt: v.cnt, fd: v.fd});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_load_hold();
        vec_t v [6] = '{
            '{HOLD, 8'h00, 0, 0, 0, 8'h00, 0, 0},
            '{LOAD, 8'h77, 0, 0, 0, 8'h00, 0, 0},
            '{LOAD, 8'hA5, 0, 0, 1, 8'hA5, 0, 0},
            '{HOLD, 8'h11, 1, 1, 1, 8'hA5, 0, 0},
            '{HOLD, 8'h22, 0, 1, 1, 8'hA5, 0, 0},
            '{HOLD, 8'h33, 1, 0, 1, 8'hA5, 0, 0}
        };
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            step8(v[i]);
            e = sb.pop_front();
            checks++;
            if (q8 !== e.q || msb8 !== e.q[7] || lsb8 !== e.q[0]) begin
                errors++;
                $display("FAIL reset_load_hold[%0d]: Q=%h msb=%b lsb=%b, required Q=%h", i, q8, msb8, lsb8, e.q);
            end
        end
    endtask

    task automatic test_serial_shift();
        vec_t v [5] = '{
            '{LOAD, 8'h81, 0, 0, 1, 8'h81, 0, 0},
            '{SHL,  8'h00, 1, 1, 1, 8'h03, 0, 0},
            '{SHR,  8'h00, 1, 0, 1, 8'h01, 0, 0},
            '{SHR,  8'h00, 0, 1, 1, 8'h80, 0, 0},
            '{SHL,  8'h00, 0, 1, 1, 8'h00, 0, 0}
        };
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            step8(v[i]);
            e = sb.pop_front();
            checks++;
            if (q8 !== e.q || msb8 !== e.q[7] || lsb8 !== e.q[0]) begin
                errors++;
                $display("FAIL serial_shift[%0d]: Q=%h msb=%b lsb=%b, required Q=%h", i, q8, msb8, lsb8, e.q);
            end
        end
    endtask

    task automatic test_rotate_asr();
        vec_t v [24] = '{
            '{LOAD, 8'h81, 0, 0, 1, 8'h81, 0, 0},
            '{ROL,  8'h00, 0, 0, 1, 8'h03, 0, 0},
            '{LOAD, 8'h81, 0, 0, 1, 8'h81, 0, 0},
            '{ROR,  8'h00, 0, 0, 1, 8'hC0, 0, 0},
            '{LOAD, 8'h90, 0, 0, 1, 8'h90, 0, 0},
            '{ASR,  8'h00, 0, 0, 1, 8'hC8, 0, 0},
            '{ASR,  8'h00, 0, 0, 1, 8'hE4, 0, 0},
            '{ASR,  8'h00, 0, 0, 1, 8'hF2, 0, 0},
            '{ASR,  8'h00, 0, 0, 1, 8'hF9, 0, 0},
            '{ASR,  8'h00, 0, 0, 1, 8'hFC, 0, 0},
            '{ASR,  8'h00, 0, 0, 1, 8'hFE, 0, 0},
            '{ASR,  8'h00, 0, 0, 1, 8'hFF, 0, 0},
            '{LOAD, 8'h40, 0, 0, 1, 8'h40, 0, 0},
            '{ASR,  8'h00, 1, 1, 1, 8'h20, 0, 0},
            '{LOAD, 8'h5A, 0, 0, 1, 8'h5A, 0, 0},
            '{ROL,  8'h00, 0, 0, 1, 8'hB4, 0, 0},
            '{ROL,  8'h00, 0, 0, 1, 8'h69, 0, 0},
            '{ROL,  8'h00, 0, 0, 1, 8'hD2, 0, 0},
            '{ROL,  8'h00, 0, 0, 1, 8'hA5, 0, 0},
            '{ROL,  8'h00, 0, 0, 1, 8'h4B, 0, 0},
            '{ROL,  8'h00, 0, 0, 1, 8'h96, 0, 0},
            '{ROL,  8'h00, 0, 0, 1, 8'h2D, 0, 0},
            '{ROL,  8'h00, 0, 0, 1, 8'h5A, 0, 0},
            '{ROR,  8'h00, 0, 0, 1, 8'h2D, 0, 0}
        };
        exp_t e;
        for (int i = 0; i < 24; i++) begin
            step8(v[i]);
            e = sb.pop_front();
            checks++;
            if (q8 !== e.q || msb8 !== e.q[7] || lsb8 !== e.q[0]) begin
                errors++;
                $display("FAIL rotate_asr[%0d]: Q=%h msb=%b lsb=%b, required Q=%h", i, q8, msb8, lsb8, e.q);
            end
        end
    endtask

    task automatic test_reset_priority();
        vec_t v [4] = '{
            '{LOAD,  8'hFF, 0, 0, 1, 8'hFF, 0, 0},
            '{LOAD,  8'h3C, 0, 0, 0, 8'h00, 0, 0},
            '{LOAD,  8'hFF, 0, 0, 1, 8'hFF, 0, 0},
            '{CLEAR, 8'h3C, 1, 1, 1, 8'h00, 0, 0}
        };
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            step8(v[i]);
            e = sb.pop_front();
            checks++;
            if (q8 !== e.q || msb8 !== e.q[7] || lsb8 !== e.q[0]) begin
                errors++;
                $display("FAIL reset_priority[%0d]: Q=%h, required Q=%h", i, q8, e.q);
            end
        end
    endtask

    task automatic test_frame_counter();
        vec_t v [21] = '{
            '{LOAD, 8'h00, 0, 0, 1, 8'h00, 0, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'h01, 1, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'h03, 2, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'h07, 3, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'h0F, 4, 0},
            '{HOLD, 8'h00, 0, 0, 1, 8'h0F, 4, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'h1F, 5, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'h3F, 6, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'h7F, 7, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'hFF, 0, 1},
            '{LOAD, 8'h00, 0, 0, 1, 8'h00, 0, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'h01, 1, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'h03, 2, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'h07, 3, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'h0F, 4, 0},
            '{HOLD, 8'h00, 0, 0, 1, 8'h0F, 4, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'h1F, 5, 0},
            '{SHL,  8'h00, 1, 0, 0, 8'h00, 0, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'h01, 1, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'h03, 2, 0},
            '{SHL,  8'h00, 1, 0, 1, 8'h07, 3, 0}
        };
        exp_t e;
        for (int i = 0; i < 21; i++) begin
            step8(v[i]);
            e = sb.pop_front();
            checks++;
`ifdef SHIFT_REG_UNIV_FRAME_EN
            if (q8 !== e.q || cnt8 !== e.cnt || fd8 !== e.fd) begin
                errors++;
                $display("FAIL frame[%0d]: Q=%h cnt=%0d frame_done=%b, required Q=%h cnt=%0d frame_done=%b",
                         i, q8, cnt8, fd8, e.q, e.cnt, e.fd);
            end
`else
            if (q8 !== e.q) begin
                errors++;
                $display("FAIL frame_q[%0d]: Q=%h, required Q=%h", i, q8, e.q);
            end
`endif
        end
    endtask

    task automatic test_min_width();
        vec_t v [5] = '{
            '{HOLD, 8'h00, 0, 0, 0, 8'h00, 0, 0},
            '{LOAD, 8'h02, 0, 0, 1, 8'h02, 0, 0},
            '{ROL,  8'h00, 0, 0, 1, 8'h01, 1, 0},
            '{ASR,  8'h00, 0, 0, 1, 8'h00, 0, 1},
            '{SHR,  8'h00, 0, 1, 1, 8'h02, 1, 0}
        };
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            step2(v[i]);
            e = sb.pop_front();
            checks++;
            if ({6'b0, q2} !== e.q || msb2 !== e.q[1] || lsb2 !== e.q[0]) begin
                errors++;
                $display("FAIL min_width[%0d]: Q=%b msb=%b lsb=%b, required Q=%b", i, q2, msb2, lsb2, e.q[1:0]);
            end
`ifdef SHIFT_REG_UNIV_FRAME_EN
            checks++;
            if ({2'b0, cnt2} !== e.cnt || fd2 !== e.fd) begin
                errors++;
                $display("FAIL min_width_frame[%0d]: cnt=%0d frame_done=%b, required cnt=%0d frame_done=%b",
                         i, cnt2, fd2, e.cnt, e.fd);
            end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset_load_hold();
        test_serial_shift();
        test_rotate_asr();
        test_reset_priority();
        test_frame_counter();
        test_min_width();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
